quad_decoder: RTL and testbench

Quadrature decoder that turns raw encoder channels A/B into direction/step strobes and a signed-agnostic position count. It is the producing end of the up/down-count interface: `o_up_down`/`o_step` feed an up/down counter's direction and enable inputs directly. It also keeps its own wrapping position register for standalone use. Asynchronous encoder pins enter through a synchronizer and glitch filter, and illegal Gray transitions are flagged.

---
 rtl/quad_pkg.sv | 51 +++++
 rtl/quad_glitch_filter.sv | 44 ++++
 rtl/quad_decoder.sv | 104 ++++++++++
 tb/tb_quad_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: Gray state constants, direction codes and the
// transition decoder used by quad_decoder.
package quad_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef struct packed {
        logic step;
        logic dir;
        logic illegal;
    } qdec_t;

    // Position of a state along the up sequence 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] qs_phase(input logic [1:0] s);
        logic [1:0] p;
        case (s)
            QS_00:   p = 2'd0;
            QS_01:   p = 2'd1;
            QS_11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    function automatic qdec_t qdec(input logic [1:0] prev, input logic [1:0] cur);
        qdec_t      r;
        logic [1:0] delta;
        r     = '0;
        delta = qs_phase(cur) - qs_phase(prev);
        case (delta)
            2'd1: begin
                r.step = 1'b1;
                r.dir  = DIR_UP;
            end
            2'd3: begin
                r.step = 1'b1;
                r.dir  = DIR_DN;
            end
            2'd2:    r.illegal = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only flips
// after the synced input has differed from it for FILT_LEN consecutive cycles.
module quad_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
            if (sync_q != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_q <= ~filt_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_q = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B channels drive step/direction strobes, a
// wrapping position counter and a sticky illegal-transition flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int FILT_LEN  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_a,
    input  logic                 i_b,
    input  logic                 i_en,
    input  logic                 i_sclr,
    output logic                 o_up_down,
    output logic                 o_step,
    output logic [BUS_WIDTH-1:0] o_pos,
    output logic                 o_err
);

    localparam int WARM_CYC = FILT_LEN + 3;
    localparam int WW       = $clog2(WARM_CYC + 1);

    logic                 a_f;
    logic                 b_f;
    logic [1:0]           cur;
    logic                 armed;
    qdec_t                dec;

    logic [WW-1:0]        warm_q,  warm_d;
    logic [1:0]           prev_q;
    logic                 step_q,  step_d;
    logic                 dir_q,   dir_d;
    logic                 err_q,   err_d;
    logic [BUS_WIDTH-1:0] pos_q,   pos_d;

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_a),
        .o_q   (a_f)
    );

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_b),
        .o_q   (b_f)
    );

    assign cur   = {a_f, b_f};
    assign armed = (warm_q == '0);
    assign dec   = qdec(prev_q, cur);

    always_comb begin
        warm_d = warm_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        err_d  = err_q;
        pos_d  = pos_q;
        if (!armed) begin
            warm_d = warm_q - 1'b1;
        end else if (i_en) begin
            if (dec.step) begin
                step_d = 1'b1;
                dir_d  = dec.dir;
                pos_d  = (dec.dir == DIR_UP) ? pos_q + BUS_WIDTH'(1)
                                             : pos_q + {BUS_WIDTH{1'b1}};
            end
            if (dec.illegal) begin
                err_d = 1'b1;
            end
        end
        // Clear wins over a same-cycle step; the strobe and direction still report it.
        if (i_sclr) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            warm_q <= WW'(WARM_CYC);
            prev_q <= QS_00;
            step_q <= 1'b0;
            dir_q  <= DIR_UP;
            err_q  <= 1'b0;
            pos_q  <= '0;
        end else begin
            warm_q <= warm_d;
            prev_q <= cur;
            step_q <= step_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
            pos_q  <= pos_d;
        end
    end

    assign o_up_down = dir_q;
    assign o_step    = step_q;
    assign o_pos     = pos_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (BUS_WIDTH=8, FILT_LEN=4): directed
// scenarios followed by random pin moves against a Gray-phase position model.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       b;
    logic       en;
    logic       sclr;
    logic       o_up_down;
    logic       o_step;
    logic [7:0] o_pos;
    logic       o_err;

    int n_vec = 0;
    int n_err = 0;
    int step_cnt = 0;

    logic [1:0] m_prev;
    logic [7:0] m_pos;
    logic       m_dir;
    logic       m_err;
    logic       m_en;

    quad_decoder #(.BUS_WIDTH(8), .FILT_LEN(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a       (a),
        .i_b       (b),
        .i_en      (en),
        .i_sclr    (sclr),
        .o_up_down (o_up_down),
        .o_step    (o_step),
        .o_pos     (o_pos),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_step === 1'b1) step_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of a pin state along the counting-up cycle 00,01,11,10.
    function automatic int phase(input logic [1:0] s);
        logic [1:0] order [4];
        int p;
        order = '{2'b00, 2'b01, 2'b11, 2'b10};
        p = 0;
        for (int i = 0; i < 4; i++) if (order[i] == s) p = i;
        return p;
    endfunction

    function automatic logic [1:0] next_up(input logic [1:0] s);
        logic [1:0] order [4];
        order = '{2'b00, 2'b01, 2'b11, 2'b10};
        return order[(phase(s) + 1) % 4];
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".pos"}, 32'(o_pos), 32'(m_pos));
        check({tag, ".err"}, 32'(o_err), 32'(m_err));
        check({tag, ".dir"}, 32'(o_up_down), 32'(m_dir));
    endtask

    // Drive a new pin state, hold it, then compare strobes and state with the model.
    task automatic move(input logic [1:0] s, input int hold, input string tag, output int lat);
        int d;
        int exp_steps;
        @(negedge clk);
        a = s[1];
        b = s[0];
        step_cnt = 0;
        lat = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (lat == 0 && step_cnt != 0) lat = i;
        end
        d = (phase(s) - phase(m_prev) + 4) % 4;
        exp_steps = 0;
        if (m_en) begin
            if (d == 1) begin
                m_pos++;
                m_dir = 1'b1;
                exp_steps = 1;
            end else if (d == 3) begin
                m_pos--;
                m_dir = 1'b0;
                exp_steps = 1;
            end else if (d == 2) begin
                m_err = 1'b1;
            end
        end
        m_prev = s;
        check({tag, ".steps"}, 32'(step_cnt), 32'(exp_steps));
        check_model(tag);
    endtask

    task automatic pulse_sclr(input string tag);
        @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        m_pos = '0;
        m_err = 1'b0;
        check_model(tag);
    endtask

    task automatic pulse_a(input int len, input int exp_steps, input string tag);
        @(negedge clk);
        a = ~a;
        step_cnt = 0;
        repeat (len) @(negedge clk);
        a = ~a;
        repeat (12) @(negedge clk);
        check({tag, ".steps"}, 32'(step_cnt), 32'(exp_steps));
        check_model(tag);
    endtask

    initial begin
        int lat;
        logic [1:0] s;

        // Power up with the encoder resting at 11.
        rst = 1'b1; a = 1'b1; b = 1'b1; en = 1'b1; sclr = 1'b0;
        m_prev = 2'b11; m_pos = '0; m_dir = 1'b1; m_err = 1'b0; m_en = 1'b1;
        #1;
        check("rst.pos", 32'(o_pos), 32'h0);
        check("rst.step", 32'(o_step), 32'h0);
        check("rst.dir", 32'(o_up_down), 32'h1);
        check("rst.err", 32'(o_err), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step_cnt = 0;
        repeat (20) @(negedge clk);
        check("pwrup11.steps", 32'(step_cnt), 32'h0);
        check_model("pwrup11");

        // Walk to 00 and clear, then the forward sequence with latency checks.
        move(2'b10, 10, "to10", lat);
        move(2'b00, 10, "to00", lat);
        pulse_sclr("clr0");
        move(2'b01, 10, "fwd1", lat); check("fwd1.lat", 32'(lat), 32'd7);
        move(2'b11, 10, "fwd2", lat); check("fwd2.lat", 32'(lat), 32'd7);
        move(2'b10, 10, "fwd3", lat); check("fwd3.lat", 32'(lat), 32'd7);
        move(2'b00, 10, "fwd4", lat); check("fwd4.lat", 32'(lat), 32'd7);
        check("fwd.pos4", 32'(o_pos), 32'h4);

        // Reverse through zero, then a full upward wrap.
        pulse_sclr("clr1");
        move(2'b10, 10, "rev1", lat); check("rev.ff", 32'(o_pos), 32'hFF);
        move(2'b11, 10, "rev2", lat); check("rev.fe", 32'(o_pos), 32'hFE);
        check("rev.dir", 32'(o_up_down), 32'h0);
        pulse_sclr("clr2");
        for (int i = 0; i < 255; i++) move(next_up(m_prev), 8, "wrapup", lat);
        check("wrap.ff", 32'(o_pos), 32'hFF);
        move(next_up(m_prev), 8, "wrap0", lat);
        check("wrap.00", 32'(o_pos), 32'h00);

        // Glitches on A starting from 01.
        while (m_prev != 2'b01) move(next_up(m_prev), 10, "to01", lat);
        pulse_a(3, 0, "glitch3");
        m_dir = 1'b0;
        pulse_a(5, 2, "glitch5");

        // Illegal 00->11, then legal counting with the flag held.
        move(2'b00, 10, "ill.to00", lat);
        move(2'b11, 10, "ill", lat);
        check("ill.err", 32'(o_err), 32'h1);
        move(2'b10, 10, "ill.up1", lat);
        move(2'b00, 10, "ill.up2", lat);
        pulse_sclr("ill.clr");

        // Disabled steps are tracked but not counted.
        en = 1'b0; m_en = 1'b0;
        for (int i = 0; i < 8; i++) move(next_up(m_prev), 10, "dis", lat);
        en = 1'b1; m_en = 1'b1;
        move(next_up(m_prev), 10, "reen", lat);

        // Clear in the same cycle the step registers.
        @(negedge clk);
        s = next_up(m_prev);
        a = s[1]; b = s[0];
        repeat (6) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        check("sclrstep.step", 32'(o_step), 32'h1);
        check("sclrstep.pos", 32'(o_pos), 32'h0);
        m_prev = s; m_pos = '0; m_err = 1'b0; m_dir = 1'b1;
        repeat (4) @(negedge clk);
        check_model("sclrstep");

        // Count to 0x25, then reset mid-operation.
        for (int i = 0; i < 37; i++) move(next_up(m_prev), 8, "to25", lat);
        check("pre_rst.pos", 32'(o_pos), 32'h25);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.pos", 32'(o_pos), 32'h0);
        check("midrst.step", 32'(o_step), 32'h0);
        check("midrst.dir", 32'(o_up_down), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        step_cnt = 0;
        m_pos = '0; m_dir = 1'b1; m_err = 1'b0;
        repeat (7) @(negedge clk);
        check("postrst7.steps", 32'(step_cnt), 32'h0);
        repeat (6) @(negedge clk);
        check("postrst.steps", 32'(step_cnt), 32'h0);
        check_model("postrst");

        // Random moves: legal, illegal or none, with enable occasionally low.
        for (int i = 0; i < 80; i++) begin
            en = ($urandom_range(0, 4) != 0);
            m_en = en;
            s = 2'($urandom_range(0, 3));
            move(s, $urandom_range(8, 14), "rand", lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
